// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state updates through per-bit JK excitation (toggle to count, set/reset to load).
// Latency: Q one cycle after the sampling edge, Wrap one cycle after the wrapping edge; TC is combinational from Q and Up.
// Backpressure: none, En gates counting. Define JK_CNT_SATURATE_EN to saturate at the limits instead of wrapping.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc;
    logic             w_cnt;

    assign w_cnt = En & ~Load;

    always_comb begin
        w_tc = Up ? (r_q == MAX_V) : (r_q == '0);
        if (Up) begin
            w_next = (r_q == MAX_V) ? '0 : r_q + ONE_V;
        end else begin
            w_next = (r_q == '0) ? MAX_V : r_q - ONE_V;
        end
`ifdef JK_CNT_SATURATE_EN
        if (w_tc) begin
            w_next = r_q;
        end
`endif
        // Out-of-range load values are forced to zero so Q never leaves 0..MODULUS-1.
        w_load = ({1'b0, D} < MOD_V) ? D : '0;

        w_j = '0;
        w_k = '0;
        if (Load) begin
            w_j = w_load;
            w_k = ~w_load;
        end else if (En) begin
            w_j = r_q ^ w_next;
            w_k = r_q ^ w_next;
        end
        w_q_nxt = (w_j & ~r_q) | (~w_k & r_q);
    end

`ifdef JK_CNT_SATURATE_EN
    logic r_sat;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_cnt & w_tc & ~r_sat;
            // Remember a blocked overflow so later blocked edges stay silent.
            if (Load) begin
                r_sat <= 1'b0;
            end else if (En) begin
                r_sat <= w_tc;
            end
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_cnt & w_tc;
        end
    end
`endif

    assign Q    = r_q;
    assign TC   = w_tc;
    assign Wrap = r_wrap;

endmodule
